// File: rtl/lidar_tiler_pkg.sv
// Shared Point Cloud Tiler definitions: packet/point layout, serializer states and lane helpers.
package lidar_tiler_pkg;

    localparam int unsigned LANES          = 4;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned POINT_W        = 32;
    localparam int unsigned COORD_W        = 10;
    localparam int unsigned X_LSB          = 0;
    localparam int unsigned Y_LSB          = 10;
    localparam int unsigned Z_LSB          = 20;
    localparam int unsigned FLAG_VALID_BIT = 30;
    localparam int unsigned FLAG_TAG_BIT   = 31;
    localparam int unsigned PACKET_W       = LANES * POINT_W;

    typedef struct packed {
        logic [1:0]         flags;
        logic [COORD_W-1:0] z;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } point_t;

    typedef logic [LANES-1:0][POINT_W-1:0] packet_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } binner_state_t;

    function automatic logic [LANES-1:0] valid_lanes(input packet_t pkt);
        logic [LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            m[i] = pkt[i][FLAG_VALID_BIT];
        end
        return m;
    endfunction

    function automatic logic [LANE_W-1:0] lowest_lane(input logic [LANES-1:0] mask);
        logic [LANE_W-1:0] sel;
        logic              found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mask[i] && !found) begin
                sel   = LANE_W'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/point_tile_binner_if.sv
// Point output stream of the tile binner: one tagged point per valid/ready transfer.
interface point_tile_binner_if #(
    parameter int unsigned TILE_SHIFT = 6
);
    import lidar_tiler_pkg::*;

    logic                              out_valid;
    logic                              out_ready;
    logic [POINT_W-1:0]                out_point;
    logic [2*(COORD_W-TILE_SHIFT)-1:0] out_tile_id;
    logic                              out_last;

    modport master (
        output out_valid,
        output out_point,
        output out_tile_id,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_point,
        input  out_tile_id,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/tile_packet_fifo.sv
// Synchronous packet FIFO; pushes are ignored when full, pops ignored when empty.
module tile_packet_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/point_tile_binner.sv
// Buffers normalized 4-point packets and streams present points one per cycle, tagged with a 2-D tile ID.
module point_tile_binner
    import lidar_tiler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TILE_SHIFT = 6,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PACKET_W-1:0]  normalized_coords,
    input  logic                 input_valid,
    input  logic                 frame_start,
    point_tile_binner_if.master  out_if,
    output logic [CNT_W-1:0]     point_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 fifo_full,
    output logic                 busy
);
    localparam int unsigned TILE_W = 2 * (COORD_W - TILE_SHIFT);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    binner_state_t     state;
    binner_state_t     state_nxt;
    packet_t           hold;
    packet_t           hold_nxt;
    packet_t           fifo_head;
    logic [LANES-1:0]  mask;
    logic [LANES-1:0]  mask_nxt;
    logic [LANES-1:0]  mask_left;
    logic [LANE_W-1:0] lane_nxt;
    point_t            pt_nxt;
    logic [TILE_W-1:0] tile_nxt;
    logic              pop;
    logic              fifo_empty;
    logic              transfer;
    logic              drop;
    logic [FCNT_W-1:0] fifo_count;

    tile_packet_fifo #(
        .WIDTH (PACKET_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (input_valid),
        .pop     (pop),
        .wr_data (normalized_coords),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign transfer = out_if.out_valid && out_if.out_ready;
    assign drop     = input_valid && fifo_full;
    assign busy     = (fifo_count != '0) || (state == ST_EMIT);

    // Outputs are computed from the next hold/mask so they are registered yet track the reload edge.
    always_comb begin
        hold_nxt  = hold;
        mask_nxt  = mask;
        pop       = 1'b0;
        mask_left = mask & (mask - 1'b1);
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    hold_nxt = fifo_head;
                    mask_nxt = valid_lanes(fifo_head);
                end
            end
            ST_EMIT: begin
                if (transfer) begin
                    mask_nxt = mask_left;
                    if (mask_left == '0 && !fifo_empty) begin
                        pop      = 1'b1;
                        hold_nxt = fifo_head;
                        mask_nxt = valid_lanes(fifo_head);
                    end
                end
            end
        endcase
        state_nxt = (mask_nxt != '0) ? ST_EMIT : ST_IDLE;
        lane_nxt  = lowest_lane(mask_nxt);
        pt_nxt    = hold_nxt[lane_nxt];
        tile_nxt  = {pt_nxt.y[COORD_W-1:TILE_SHIFT], pt_nxt.x[COORD_W-1:TILE_SHIFT]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            hold               <= '0;
            mask               <= '0;
            out_if.out_valid   <= 1'b0;
            out_if.out_point   <= '0;
            out_if.out_tile_id <= '0;
            out_if.out_last    <= 1'b0;
        end else begin
            state              <= state_nxt;
            hold               <= hold_nxt;
            mask               <= mask_nxt;
            out_if.out_valid   <= (state_nxt == ST_EMIT);
            out_if.out_point   <= pt_nxt;
            out_if.out_tile_id <= tile_nxt;
            out_if.out_last    <= $onehot(mask_nxt);
        end
    end

    // frame_start restarts each counter but still counts an event landing on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            point_count <= '0;
            drop_count  <= '0;
        end else begin
            if (frame_start) begin
                point_count <= CNT_W'(transfer);
            end else if (transfer && point_count != '1) begin
                point_count <= point_count + 1'b1;
            end
            if (frame_start) begin
                drop_count <= CNT_W'(drop);
            end else if (drop && drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_point_tile_binner.sv
// Directed and randomized bench for point_tile_binner against a queue-based beat model.
module tb_point_tile_binner;
    localparam int unsigned S      = 6;
    localparam int unsigned CW     = 5;
    localparam int unsigned CMAX   = (1 << CW) - 1;
    localparam int unsigned DLIMIT = 300;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [127:0]   normalized_coords = '0;
    logic           input_valid = 1'b0;
    logic           frame_start = 1'b0;
    logic [CW-1:0]  point_count;
    logic [CW-1:0]  drop_count;
    logic           fifo_full;
    logic           busy;

    point_tile_binner_if #(.TILE_SHIFT(S)) bif ();

    point_tile_binner #(
        .FIFO_DEPTH (4),
        .TILE_SHIFT (S),
        .CNT_W      (CW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .normalized_coords (normalized_coords),
        .input_valid       (input_valid),
        .frame_start       (frame_start),
        .out_if            (bif),
        .point_count       (point_count),
        .drop_count        (drop_count),
        .fifo_full         (fifo_full),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] point;
        int unsigned tile;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned n_assert   = 0;
    int unsigned n_fail     = 0;
    int unsigned exp_points = 0;
    int unsigned exp_drops  = 0;

    function automatic int unsigned sat(input int unsigned v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected beats: every lane with flag bit 30, in lane order, tile from plain arithmetic.
    task automatic model_push(input logic [127:0] pkt);
        int unsigned last_lane;
        logic [31:0] w;
        beat_t       e;
        last_lane = 0;
        for (int unsigned i = 0; i < 4; i++) if (pkt[i*32+30]) last_lane = i;
        for (int unsigned i = 0; i < 4; i++) begin
            w = pkt[i*32 +: 32];
            if (w[30]) begin
                e.point = w;
                e.tile  = ((32'(w[19:10]) >> S) * (1024 >> S)) + (32'(w[9:0]) >> S);
                e.last  = (i == last_lane);
                exp_q.push_back(e);
                exp_points++;
            end
        end
    endtask

    function automatic logic [127:0] rand_pkt();
        logic [127:0] p;
        for (int unsigned i = 0; i < 4; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [127:0] full_pkt();
        logic [127:0] p;
        p = rand_pkt();
        for (int unsigned i = 0; i < 4; i++) p[i*32+30] = 1'b1;
        return p;
    endfunction

    function automatic logic [31:0] mk_lane(input int unsigned x, input int unsigned y,
                                            input int unsigned z, input int unsigned fl);
        logic [31:0] w;
        w[9:0]   = x[9:0];
        w[19:10] = y[9:0];
        w[29:20] = z[9:0];
        w[31:30] = fl[1:0];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] p);
        normalized_coords = p;
        input_valid       = 1'b1;
        model_push(p);
        tick();
        input_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        bif.out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy || bif.out_valid) && n < DLIMIT) begin
            tick();
            n++;
        end
        check("drain_done", 64'(n < DLIMIT), 64'd1);
    endtask

    // Monitor: every transfer must match the model head; stalled beats must not change.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_point;
    logic [7:0]  prev_tile;
    logic        prev_last;
    beat_t       mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(bif.out_valid), 64'd1);
                check("stall_point", 64'(bif.out_point), 64'(prev_point));
                check("stall_tile", 64'(bif.out_tile_id), 64'(prev_tile));
                check("stall_last", 64'(bif.out_last), 64'(prev_last));
            end
            if (bif.out_valid && bif.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 64'(bif.out_point), 64'hDEAD_0000_0000);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_point", 64'(bif.out_point), 64'(mon_e.point));
                    check("beat_tile", 64'(bif.out_tile_id), 64'(mon_e.tile));
                    check("beat_last", 64'(bif.out_last), 64'(mon_e.last));
                end
            end
            prev_stall = bif.out_valid && !bif.out_ready;
            prev_point = bif.out_point;
            prev_tile  = bif.out_tile_id;
            prev_last  = bif.out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p;
        logic [127:0] q;
        bif.out_ready = 1'b0;
        #12;
        check("rst_valid", 64'(bif.out_valid), 64'd0);
        check("rst_point", 64'(bif.out_point), 64'd0);
        check("rst_tile", 64'(bif.out_tile_id), 64'd0);
        check("rst_last", 64'(bif.out_last), 64'd0);
        check("rst_pcount", 64'(point_count), 64'd0);
        check("rst_dcount", 64'(drop_count), 64'd0);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single packet, all lanes present, latency and out_last placement
        bif.out_ready = 1'b1;
        p = full_pkt();
        send(p);
        check("lat_edge_n", 64'(bif.out_valid), 64'd0);
        check("lat_busy", 64'(busy), 64'd1);
        tick();
        check("beat0_lane0", 64'(bif.out_point), 64'(p[31:0]));
        for (int unsigned b = 0; b < 4; b++) begin
            check("single_valid", 64'(bif.out_valid), 64'd1);
            check("single_last", 64'(bif.out_last), 64'(b == 3));
            tick();
        end
        check("single_done", 64'(bif.out_valid), 64'd0);
        check("single_pcount", 64'(point_count), 64'(sat(exp_points)));

        // Tile arithmetic corners; lane 2 absent, flag bit 31 passes through
        p[31:0]   = mk_lane(130, 70, 5, 1);
        p[63:32]  = mk_lane(1023, 1023, 0, 3);
        p[95:64]  = mk_lane(0, 0, 0, 0);
        p[127:96] = mk_lane(64, 0, 9, 1);
        send(p);
        tick();
        check("tile_18", 64'(bif.out_tile_id), 64'd18);
        tick();
        check("tile_255", 64'(bif.out_tile_id), 64'd255);
        check("tag_bit", 64'(bif.out_point[31]), 64'd1);
        tick();
        check("tile_1", 64'(bif.out_tile_id), 64'd1);
        check("tile_last", 64'(bif.out_last), 64'd1);
        drain();

        // Sparse lanes 1 and 3, then an empty packet
        p = rand_pkt();
        for (int unsigned i = 0; i < 4; i++) p[i*32+30] = (i == 1 || i == 3);
        send(p);
        tick();
        check("sparse_lane1", 64'(bif.out_point), 64'(p[63:32]));
        check("sparse_last1", 64'(bif.out_last), 64'd0);
        tick();
        check("sparse_lane3", 64'(bif.out_point), 64'(p[127:96]));
        check("sparse_last3", 64'(bif.out_last), 64'd1);
        tick();
        check("sparse_done", 64'(bif.out_valid), 64'd0);
        q = rand_pkt();
        for (int unsigned i = 0; i < 4; i++) q[i*32+30] = 1'b0;
        send(q);
        repeat (4) tick();
        check("empty_pcount", 64'(point_count), 64'(sat(exp_points)));
        check("empty_busy", 64'(busy), 64'd0);

        // Overflow with downstream stalled: 4 in FIFO + 1 held, 6th dropped
        bif.out_ready = 1'b0;
        for (int unsigned k = 0; k < 6; k++) begin
            p = rand_pkt();
            p[30] = 1'b1;
            normalized_coords = p;
            input_valid = 1'b1;
            if (k < 5) model_push(p);
            tick();
            if (k == 3) check("ovf_not_full", 64'(fifo_full), 64'd0);
            if (k == 4) check("ovf_full", 64'(fifo_full), 64'd1);
        end
        input_valid = 1'b0;
        exp_drops++;
        check("ovf_drop", 64'(drop_count), 64'(sat(exp_drops)));
        repeat (5) tick();
        check("ovf_stalled_valid", 64'(bif.out_valid), 64'd1);
        drain();
        check("ovf_pcount", 64'(point_count), 64'(sat(exp_points)));
        check("ovf_dcount", 64'(drop_count), 64'(sat(exp_drops)));

        // Back-to-back packets: 8 beats without a bubble
        bif.out_ready = 1'b1;
        send(full_pkt());
        send(full_pkt());
        for (int unsigned b = 0; b < 8; b++) begin
            check("b2b_valid", 64'(bif.out_valid), 64'd1);
            check("b2b_last", 64'(bif.out_last), 64'(b == 3 || b == 7));
            tick();
        end
        check("b2b_done", 64'(bif.out_valid), 64'd0);

        // Toggling ready
        send(full_pkt());
        send(full_pkt());
        for (int unsigned c = 0; c < 20; c++) begin
            bif.out_ready = 1'(c % 2);
            tick();
        end
        drain();

        // Random packets, ready forced high every other cycle so the FIFO never fills
        for (int unsigned k = 0; k < 40; k++) begin
            p = rand_pkt();
            normalized_coords = p;
            input_valid = 1'b1;
            model_push(p);
            bif.out_ready = 1'b1;
            tick();
            input_valid = 1'b0;
            for (int unsigned c = 0; c < 9; c++) begin
                bif.out_ready = (c % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                tick();
            end
        end
        drain();
        check("rand_pcount_sat", 64'(point_count), 64'(sat(exp_points)));
        check("rand_dcount", 64'(drop_count), 64'(sat(exp_drops)));

        // frame_start on the same edge as a transfer
        bif.out_ready = 1'b1;
        send(full_pkt());
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_pcount", 64'(point_count), 64'd1);
        check("fs_dcount", 64'(drop_count), 64'd0);
        exp_points = 1 + exp_q.size();
        exp_drops  = 0;
        drain();
        check("fs_pcount_end", 64'(point_count), 64'(sat(exp_points)));

        // Reset in the middle of EMIT
        bif.out_ready = 1'b0;
        send(full_pkt());
        send(full_pkt());
        check("pre_rst_valid", 64'(bif.out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bif.out_valid), 64'd0);
        check("mid_rst_point", 64'(bif.out_point), 64'd0);
        check("mid_rst_tile", 64'(bif.out_tile_id), 64'd0);
        check("mid_rst_last", 64'(bif.out_last), 64'd0);
        check("mid_rst_pcount", 64'(point_count), 64'd0);
        check("mid_rst_full", 64'(fifo_full), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        exp_points = 0;
        exp_drops  = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        bif.out_ready = 1'b1;
        p = full_pkt();
        send(p);
        check("fresh_lat_n", 64'(bif.out_valid), 64'd0);
        tick();
        check("fresh_valid", 64'(bif.out_valid), 64'd1);
        check("fresh_lane0", 64'(bif.out_point), 64'(p[31:0]));
        drain();
        check("fresh_pcount", 64'(point_count), 64'(sat(exp_points)));
        check("fresh_dcount", 64'(drop_count), 64'(sat(exp_drops)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
